pad_mux_ctrl: RTL

Runtime controller for the user-project IO pad multiplexer. It holds one function-select code per pad (GPIO, ALT1, ALT2, OFF) and drives the select lines that the pad wrapper uses to steer io_out/io_oeb between GPIO and the peripherals (SPI, UART, PWM). Every owner change passes through a guarded switch sequence: the pad is held tri-stated for a fixed number of cycles before the new owner is committed, so a switch cannot glitch an external device. Configuration arrives over a simple req/gnt register port driven by the SoC peripheral bus.

---
 rtl/pad_mux_pkg.sv | 28 ++
 rtl/pad_guard_timer.sv | 39 +++
 rtl/pad_mux_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pad_mux_pkg.sv
// Shared types and constants for the IO pad multiplexer controller.
//   pad_func_e   : per-pad function-select code (GPIO / ALT1 / ALT2 / OFF)
//   ctrl_state_e : guarded switch sequencer states
//   PAD_IDX_W    : width of the pad index on the config port
//   FUNC_W       : width of a function code
//   RESET_FUNC   : function code every pad takes on reset
package pad_mux_pkg;

  localparam int PAD_IDX_W = 6;
  localparam int FUNC_W    = 2;

  typedef enum logic [1:0] {
    FUNC_GPIO = 2'd0,
    FUNC_ALT1 = 2'd1,
    FUNC_ALT2 = 2'd2,
    FUNC_OFF  = 2'd3
  } pad_func_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_RELEASE = 2'd3
  } ctrl_state_e;

  localparam pad_func_e RESET_FUNC = FUNC_GPIO;

endpackage

// File: rtl/pad_guard_timer.sv
// Loadable down-counter that times the tri-state guard interval.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one (saturates at zero)
//   value_o    : current count
//   zero_o     : count is zero
module pad_guard_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] value_r;

  // Count register: load wins, otherwise decrement without wrapping below zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_r <= {CNT_W{1'b0}};
    end else if (load_i) begin
      value_r <= load_val_i;
    end else if (dec_i && (value_r != {CNT_W{1'b0}})) begin
      value_r <= value_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      value_r <= value_r;
    end
  end

  assign value_o = value_r;
  assign zero_o  = (value_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pad_mux_ctrl.sv
// Runtime controller for the user-project IO pad multiplexer.
// Holds one function code per pad and walks every owner change through
// HOLD -> COMMIT -> RELEASE so the pad sits tri-stated before the new owner
// takes it.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   cfg_req_i/we/addr/wdata/lock : config request from the peripheral bus
//   cfg_gnt_o          : request accepted this cycle (combinational)
//   cfg_rvalid_o       : one-cycle response pulse, with cfg_rdata_o/cfg_err_o
//   pad_sel_o          : committed code per pad, pad p at [2p+1:2p]
//   pad_hold_o         : per-pad force tri-state
//   busy_o             : switch sequence in progress
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int NUM_PADS     = 38,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_req_i,
  input  logic                       cfg_we_i,
  input  logic [PAD_IDX_W-1:0]       cfg_addr_i,
  input  logic [FUNC_W-1:0]          cfg_wdata_i,
  input  logic                       cfg_lock_i,
  output logic                       cfg_gnt_o,
  output logic                       cfg_rvalid_o,
  output logic [FUNC_W-1:0]          cfg_rdata_o,
  output logic                       cfg_err_o,
  output logic [FUNC_W*NUM_PADS-1:0] pad_sel_o,
  output logic [NUM_PADS-1:0]        pad_hold_o,
  output logic                       busy_o
);

  localparam int               CNT_W      = $clog2(GUARD_CYCLES + 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [FUNC_W-1:0] RESET_CODE = RESET_FUNC;

  ctrl_state_e                state_r, state_nxt_s;
  logic [FUNC_W*NUM_PADS-1:0] sel_r;
  logic [NUM_PADS-1:0]        hold_r;
  logic                       busy_r, rvalid_r, err_r;
  logic [FUNC_W-1:0]          rdata_r, code_r;
  logic [PAD_IDX_W-1:0]       idx_r;

  logic                       accept_s, in_range_s, start_switch_s;
  logic                       imm_rsp_s, imm_err_s, timer_dec_s;
  logic                       commit_s, done_s, timer_zero_s;
  logic [FUNC_W-1:0]          cur_sel_s;
  logic [CNT_W-1:0]           timer_value_s;

  // One-hot pad mask; out-of-range indices give an all-zero mask.
  function automatic logic [NUM_PADS-1:0] pad_onehot(input logic [PAD_IDX_W-1:0] idx);
    logic [NUM_PADS-1:0] m;
    m = {NUM_PADS{1'b0}};
    for (int p = 0; p < NUM_PADS; p++) begin
      m[p] = (int'(idx) == p);
    end
    return m;
  endfunction

  // Code of one pad; out-of-range indices read as zero.
  function automatic logic [FUNC_W-1:0] pad_code(input logic [FUNC_W*NUM_PADS-1:0] sel,
                                                  input logic [PAD_IDX_W-1:0]       idx);
    logic [FUNC_W-1:0] r;
    r = {FUNC_W{1'b0}};
    for (int p = 0; p < NUM_PADS; p++) begin
      if (int'(idx) == p) begin
        r = sel[p*FUNC_W +: FUNC_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign in_range_s = (int'(cfg_addr_i) < NUM_PADS);
  assign cur_sel_s  = pad_code(sel_r, cfg_addr_i);

  pad_guard_timer #(.CNT_W(CNT_W)) u_guard_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (start_switch_s),
    .load_val_i (GUARD_LOAD),
    .dec_i      (timer_dec_s),
    .value_o    (timer_value_s),
    .zero_o     (timer_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_switch_s) state_nxt_s = ST_HOLD;
        else                state_nxt_s = ST_IDLE;
      end
      ST_HOLD: begin
        if (timer_zero_s) state_nxt_s = ST_COMMIT;
        else              state_nxt_s = ST_HOLD;
      end
      ST_COMMIT:  state_nxt_s = ST_RELEASE;
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: accept, immediate responses (lock > range > no-change), switch phases.
  always_comb begin
    accept_s       = 1'b0;
    start_switch_s = 1'b0;
    imm_rsp_s      = 1'b0;
    imm_err_s      = 1'b0;
    timer_dec_s    = 1'b0;
    commit_s       = 1'b0;
    done_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = cfg_req_i;
        if (cfg_req_i) begin
          imm_rsp_s = 1'b1;
          if (!cfg_we_i) begin
            imm_err_s = !in_range_s;
          end else if (cfg_lock_i || !in_range_s) begin
            imm_err_s = 1'b1;
          end else if (cfg_wdata_i == cur_sel_s) begin
            imm_err_s = 1'b0;
          end else begin
            imm_rsp_s      = 1'b0;
            start_switch_s = 1'b1;
          end
        end else begin
          imm_rsp_s = 1'b0;
        end
      end
      ST_HOLD:    timer_dec_s = (timer_value_s != {CNT_W{1'b0}});
      ST_COMMIT:  commit_s    = 1'b1;
      ST_RELEASE: done_s      = 1'b1;
      default:    accept_s    = 1'b0;
    endcase
  end

  // Response register: immediate answers at T+1, switch completion one cycle after RELEASE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= {FUNC_W{1'b0}};
    end else begin
      if (imm_rsp_s) begin
        rvalid_r <= 1'b1;
        err_r    <= imm_err_s;
      end else if (done_s) begin
        rvalid_r <= 1'b1;
        err_r    <= 1'b0;
      end else begin
        rvalid_r <= 1'b0;
        err_r    <= 1'b0;
      end
      // Only reads refresh rdata; it otherwise keeps its last value.
      if (imm_rsp_s && !cfg_we_i) rdata_r <= cur_sel_s;
      else                        rdata_r <= rdata_r;
    end
  end

  // Switch bookkeeping: latch target, drive hold/busy across HOLD..RELEASE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_r  <= {PAD_IDX_W{1'b0}};
      code_r <= {FUNC_W{1'b0}};
      hold_r <= {NUM_PADS{1'b0}};
      busy_r <= 1'b0;
    end else if (start_switch_s) begin
      idx_r  <= cfg_addr_i;
      code_r <= cfg_wdata_i;
      hold_r <= hold_r | pad_onehot(cfg_addr_i);
      busy_r <= 1'b1;
    end else if (done_s) begin
      hold_r <= hold_r & ~pad_onehot(idx_r);
      busy_r <= 1'b0;
    end else begin
      hold_r <= hold_r;
      busy_r <= busy_r;
    end
  end

  // Committed function codes; only the latched pad changes, at the end of COMMIT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_r <= {NUM_PADS{RESET_CODE}};
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (commit_s && (int'(idx_r) == p)) sel_r[p*FUNC_W +: FUNC_W] <= code_r;
        else                                sel_r[p*FUNC_W +: FUNC_W] <= sel_r[p*FUNC_W +: FUNC_W];
      end
    end
  end

  assign cfg_gnt_o    = accept_s;
  assign cfg_rvalid_o = rvalid_r;
  assign cfg_rdata_o  = rdata_r;
  assign cfg_err_o    = err_r;
  assign pad_sel_o    = sel_r;
  assign pad_hold_o   = hold_r;
  assign busy_o       = busy_r;

endmodule
